// File: rtl/mips_cpu_mem_unit.sv
// -----------------------------------------------------------------------------
// mips_cpu_mem_unit
//
// Load/store unit sitting between the MIPS core and an Avalon-MM master port.
// It takes one memory op at a time. For each op it issues one Avalon read
// (loads) or one Avalon write (stores) and honours waitrequest. It then
// returns load data, extended or merged as the op requires (LWL/LWR merge with
// the current rt value). Misaligned and illegal ops finish without any bus
// cycle and raise resp_err.
//
// Optional feature (compile-time macro MEM_UNIT_TIMEOUT_EN):
//   When the macro is defined, a counter aborts an access that has seen
//   TIMEOUT_CYCLES waitrequest-high cycles. The unit then responds with
//   resp_err=1. When the macro is undefined, ACCESS waits on waitrequest
//   for as long as it takes.
//
// Parameters:
//   ADDR_W          byte-address width (Avalon address is word aligned)
//   TIMEOUT_CYCLES  waitrequest-high cycles tolerated before abort
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready           op handshake, req_ready high only when idle
//   req_op, req_addr              op code and effective byte address
//   req_wdata, req_rt             store data and rt (LWL/LWR merge source)
//   resp_valid/resp_data/resp_err one-cycle completion pulse with result
//   address/read/write/waitrequest/writedata/byteenable/readdata
//                                 Avalon-MM master signals
// -----------------------------------------------------------------------------
module mips_cpu_mem_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_rt,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);

    localparam logic [3:0] OP_LW  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LHU = 4'h2;
    localparam logic [3:0] OP_LB  = 4'h3;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LWL = 4'h5;
    localparam logic [3:0] OP_LWR = 4'h6;
    localparam logic [3:0] OP_SW  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SB  = 4'hA;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] address_reg, address_next;
    logic [31:0]       writedata_reg, writedata_next;
    logic [3:0]        byteenable_reg, byteenable_next;
    logic              read_reg, read_next;
    logic              write_reg, write_next;
    logic [3:0]        op_reg, op_next;
    logic [1:0]        k_reg, k_next;
    logic [31:0]       rt_reg, rt_next;
    logic [31:0]       resp_data_reg, resp_data_next;
    logic              resp_err_reg, resp_err_next;

`ifdef MEM_UNIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
`endif

    // ------------------------------------------------------------------
    // Request decode (only meaningful while idle)
    // ------------------------------------------------------------------
    logic [1:0]  req_k;
    logic        req_legal;
    logic        req_store;
    logic        req_misalign;
    logic [3:0]  req_be;
    logic [31:0] req_wd;

    assign req_k = req_addr[1:0];

    always_comb begin
        req_legal    = 1'b1;
        req_store    = 1'b0;
        req_misalign = 1'b0;
        req_be       = 4'b1111;     // loads always fetch the whole word
        req_wd       = 32'h0;
        case (req_op)
            OP_LW:                 req_misalign = |req_k;
            OP_LH, OP_LHU:         req_misalign = req_k[0];
            OP_LB, OP_LBU,
            OP_LWL, OP_LWR:        req_misalign = 1'b0;
            OP_SW: begin
                req_store    = 1'b1;
                req_misalign = |req_k;
                req_wd       = req_wdata;
            end
            OP_SH: begin
                req_store    = 1'b1;
                req_misalign = req_k[0];
                req_be       = req_k[1] ? 4'b1100 : 4'b0011;
                req_wd       = {2{req_wdata[15:0]}};
            end
            OP_SB: begin
                req_store = 1'b1;
                req_be    = 4'b0001 << req_k;
                req_wd    = {4{req_wdata[7:0]}};
            end
            default:               req_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Load result formatting from the registered op/offset/rt
    // ------------------------------------------------------------------
    logic [7:0] rd_byte [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = readdata[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = rd_byte[k_reg];
        ld_half = k_reg[1] ? readdata[31:16] : readdata[15:0];
        ld_data = 32'h0;
        case (op_reg)
            OP_LW:  ld_data = readdata;
            OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU: ld_data = {16'h0, ld_half};
            OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU: ld_data = {24'h0, ld_byte};
            OP_LWL: begin
                case (k_reg)
                    2'd0:    ld_data = {rd_byte[0], rt_reg[23:0]};
                    2'd1:    ld_data = {rd_byte[1], rd_byte[0], rt_reg[15:0]};
                    2'd2:    ld_data = {rd_byte[2], rd_byte[1], rd_byte[0], rt_reg[7:0]};
                    default: ld_data = readdata;
                endcase
            end
            OP_LWR: begin
                case (k_reg)
                    2'd0:    ld_data = readdata;
                    2'd1:    ld_data = {rt_reg[31:24], rd_byte[3], rd_byte[2], rd_byte[1]};
                    2'd2:    ld_data = {rt_reg[31:16], rd_byte[3], rd_byte[2]};
                    default: ld_data = {rt_reg[31:8], rd_byte[3]};
                endcase
            end
            default: ld_data = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        address_next    = address_reg;
        writedata_next  = writedata_reg;
        byteenable_next = byteenable_reg;
        read_next       = read_reg;
        write_next      = write_reg;
        op_next         = op_reg;
        k_next          = k_reg;
        rt_next         = rt_reg;
        resp_data_next  = resp_data_reg;
        resp_err_next   = resp_err_reg;
`ifdef MEM_UNIT_TIMEOUT_EN
        tmo_cnt_next    = tmo_cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    op_next      = req_op;
                    k_next       = req_k;
                    rt_next      = req_rt;
                    address_next = {req_addr[ADDR_W-1:2], 2'b00};
`ifdef MEM_UNIT_TIMEOUT_EN
                    tmo_cnt_next = '0;
`endif
                    if (!req_legal || req_misalign) begin
                        // Rejected op: report straight away, no bus cycle.
                        state_next     = S_RESP;
                        resp_err_next  = 1'b1;
                        resp_data_next = 32'h0;
                    end else begin
                        state_next      = S_ACCESS;
                        read_next       = !req_store;
                        write_next      = req_store;
                        byteenable_next = req_be;
                        writedata_next  = req_wd;
                    end
                end
            end
            S_ACCESS: begin
                if (!waitrequest) begin
                    state_next     = S_RESP;
                    read_next      = 1'b0;
                    write_next     = 1'b0;
                    resp_err_next  = 1'b0;
                    resp_data_next = write_reg ? 32'h0 : ld_data;
                end
`ifdef MEM_UNIT_TIMEOUT_EN
                // The current cycle is the TIMEOUT_CYCLES-th stalled one.
                else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next     = S_RESP;
                    read_next      = 1'b0;
                    write_next     = 1'b0;
                    resp_err_next  = 1'b1;
                    resp_data_next = 32'h0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
`endif
            end
            default: begin  // S_RESP: single-cycle response, then back to idle
                state_next     = S_IDLE;
                resp_err_next  = 1'b0;
                resp_data_next = 32'h0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            address_reg    <= '0;
            writedata_reg  <= 32'h0;
            byteenable_reg <= 4'h0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            op_reg         <= 4'h0;
            k_reg          <= 2'd0;
            rt_reg         <= 32'h0;
            resp_data_reg  <= 32'h0;
            resp_err_reg   <= 1'b0;
`ifdef MEM_UNIT_TIMEOUT_EN
            tmo_cnt_reg    <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            address_reg    <= address_next;
            writedata_reg  <= writedata_next;
            byteenable_reg <= byteenable_next;
            read_reg       <= read_next;
            write_reg      <= write_next;
            op_reg         <= op_next;
            k_reg          <= k_next;
            rt_reg         <= rt_next;
            resp_data_reg  <= resp_data_next;
            resp_err_reg   <= resp_err_next;
`ifdef MEM_UNIT_TIMEOUT_EN
            tmo_cnt_reg    <= tmo_cnt_next;
`endif
        end
    end

    assign req_ready  = (state_reg == S_IDLE);
    assign resp_valid = (state_reg == S_RESP);
    assign resp_data  = resp_data_reg;
    assign resp_err   = resp_err_reg;
    assign address    = address_reg;
    assign read       = read_reg;
    assign write      = write_reg;
    assign writedata  = writedata_reg;
    assign byteenable = byteenable_reg;

endmodule
